// File: rtl/pll_ctrl.sv
// PLL control sequencer: takes divisor-change requests, steps the PLL through
// bypass/settle/lock phases and flags when the PLL output clock is safe to use.
module pll_ctrl #(
   parameter int REF_DEV_WIDTH = 4,
   parameter int FB_DIV_WIDTH  = 8,
   parameter int RST_REFDIV    = 1,
   parameter int RST_FBDIV     = 1,
   parameter int SWITCH_CYCLES = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter int LOCK_TIMEOUT  = 4096
) (
   input  logic                     clk_i,
   input  logic                     arst_ni,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [REF_DEV_WIDTH-1:0] req_refdiv_i,
   input  logic [FB_DIV_WIDTH-1:0]  req_fbdiv_i,
   output logic [REF_DEV_WIDTH-1:0] refdiv_o,
   output logic [FB_DIV_WIDTH-1:0]  fbdiv_o,
   input  logic                     pll_locked_i,
   output logic                     use_pll_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic                     lock_lost_o
);

   localparam int MAX_AB  = (SWITCH_CYCLES > SETTLE_CYCLES) ? SWITCH_CYCLES : SETTLE_CYCLES;
   localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CYC);
   localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SWITCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] ST_LAST   = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_BYPASS    = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_WAIT_LOCK = 3'd3,
      ST_LOCKED    = 3'd4,
      ST_FAIL      = 3'd5
   } state_e;

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     sync1_q, lock_q;
   logic [REF_DEV_WIDTH-1:0] pend_ref_q, pend_ref_d, refdiv_q, refdiv_d;
   logic [FB_DIV_WIDTH-1:0]  pend_fb_q, pend_fb_d, fbdiv_q, fbdiv_d;
   logic                     use_pll_q, use_pll_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
   logic                     lost_q, lost_d;
   logic                     accept_s;

   assign req_ready_o = (state_q == ST_IDLE) || (state_q == ST_LOCKED) || (state_q == ST_FAIL);
   assign accept_s    = req_valid_i & req_ready_o;

   assign refdiv_o    = refdiv_q;
   assign fbdiv_o     = fbdiv_q;
   assign use_pll_o   = use_pll_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign lock_lost_o = lost_q;

   // Two-flop synchronizer for the asynchronous PLL lock indication
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         sync1_q <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         sync1_q <= pll_locked_i;
         lock_q  <= sync1_q;
      end
   end

   // Next-state, divisor and registered-output decode
   always_comb begin
      state_d    = state_q;
      pend_ref_d = pend_ref_q;
      pend_fb_d  = pend_fb_q;
      refdiv_d   = refdiv_q;
      fbdiv_d    = fbdiv_q;
      lost_d     = 1'b0;
      cnt_d      = cnt_q;

      case (state_q)
         ST_IDLE, ST_FAIL: begin
            if (accept_s) state_d = ST_BYPASS;
            else          state_d = state_q;
         end
         ST_BYPASS: begin
            if (cnt_q == SW_LAST) begin
               state_d  = ST_SETTLE;
               refdiv_d = pend_ref_q;
               fbdiv_d  = pend_fb_q;
            end else begin
               state_d  = ST_BYPASS;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == ST_LAST) state_d = ST_WAIT_LOCK;
            else                  state_d = ST_SETTLE;
         end
         ST_WAIT_LOCK: begin
            if (lock_q)                 state_d = ST_LOCKED;
            else if (cnt_q == TO_LAST)  state_d = ST_FAIL;
            else                        state_d = ST_WAIT_LOCK;
         end
         ST_LOCKED: begin
            // A request takes priority over a simultaneous lock drop
            if (accept_s) begin
               state_d = ST_BYPASS;
            end else if (!lock_q) begin
               state_d = ST_WAIT_LOCK;
               lost_d  = 1'b1;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept_s) begin
         pend_ref_d = req_refdiv_i;
         pend_fb_d  = req_fbdiv_i;
      end else begin
         pend_ref_d = pend_ref_q;
         pend_fb_d  = pend_fb_q;
      end

      if (state_d != state_q)   cnt_d = CNT_ZERO;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      else                       cnt_d = cnt_q;

      use_pll_d = (state_d == ST_LOCKED);
      busy_d    = (state_d == ST_BYPASS) || (state_d == ST_SETTLE) || (state_d == ST_WAIT_LOCK);
      done_d    = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);
      err_d     = (state_d == ST_FAIL) && (state_q != ST_FAIL);
   end

   // State, counter, divisor and status registers
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q    <= ST_IDLE;
         cnt_q      <= CNT_ZERO;
         pend_ref_q <= REF_DEV_WIDTH'(RST_REFDIV);
         pend_fb_q  <= FB_DIV_WIDTH'(RST_FBDIV);
         refdiv_q   <= REF_DEV_WIDTH'(RST_REFDIV);
         fbdiv_q    <= FB_DIV_WIDTH'(RST_FBDIV);
         use_pll_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_ref_q <= pend_ref_d;
         pend_fb_q  <= pend_fb_d;
         refdiv_q   <= refdiv_d;
         fbdiv_q    <= fbdiv_d;
         use_pll_q  <= use_pll_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         lost_q     <= lost_d;
      end
   end

endmodule
